// File: rtl/apb_master_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb_master_bridge : valid/ready command stream to APB SETUP/ACCESS master |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module apb_master_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        wait_cnt, wait_cnt_nxt;
  logic                    psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_WIDTH-1:0]   paddr_nxt;
  logic [DATA_WIDTH-1:0]   pwdata_nxt, rsp_rdata_nxt;
  logic                    rsp_valid_nxt, rsp_err_nxt;
  logic                    timed_out;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  // Abort on the edge that would close the TIMEOUT-th low-PREADY ACCESS cycle.
  assign timed_out = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);

  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    psel_nxt      = PSEL;
    penable_nxt   = PENABLE;
    pwrite_nxt    = PWRITE;
    paddr_nxt     = PADDR;
    pwdata_nxt    = PWDATA;
    rsp_valid_nxt = 1'b0;
    rsp_err_nxt   = rsp_err;
    rsp_rdata_nxt = rsp_rdata;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_nxt  = cmd_write;
          paddr_nxt   = cmd_addr;
          pwdata_nxt  = cmd_wdata;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          state_nxt   = SETUP;
        end
      end
      SETUP: begin
        penable_nxt  = 1'b1;
        wait_cnt_nxt = '0;
        state_nxt    = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = PSLVERR;
          rsp_rdata_nxt = (!PWRITE && !PSLVERR) ? PRDATA : '0;
          state_nxt     = IDLE;
        end else if (timed_out) begin
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b1;
          rsp_rdata_nxt = '0;
          state_nxt     = IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: begin
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
        state_nxt   = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      PSEL      <= psel_nxt;
      PENABLE   <= penable_nxt;
      PWRITE    <= pwrite_nxt;
      PADDR     <= paddr_nxt;
      PWDATA    <= pwdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_err   <= rsp_err_nxt;
      rsp_rdata <= rsp_rdata_nxt;
    end
  end

endmodule
`default_nettype wire
